// File: rtl/chroni_font_shifter_pkg.sv
// Shared constants and types for the Chroni font shifter: default widths,
// FIFO entry field layout and the shifter state encoding.
package chroni_font_shifter_pkg;

  localparam int PIX_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Entry layout, LSB first: {last, bg, fg, byte}. The fg/bg/last offsets
  // depend on the colour width, so they are derived by the helpers below.
  localparam int BYTE_LSB = 0;
  localparam int BYTE_W   = 8;
  localparam int FG_LSB   = BYTE_LSB + BYTE_W;

  function automatic int entry_width(input int pix_w);
    return BYTE_W + 2 * pix_w + 1;
  endfunction

  function automatic int bg_lsb(input int pix_w);
    return FG_LSB + pix_w;
  endfunction

  function automatic int last_bit(input int pix_w);
    return FG_LSB + 2 * pix_w;
  endfunction

  typedef enum logic {
    SHIFT_EMPTY  = 1'b0,
    SHIFT_LOADED = 1'b1
  } shift_state_e;

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

endpackage

// File: rtl/chroni_font_shifter_if.sv
// Font entry stream from the glyph decoder into the shifter (valid/ready).
interface chroni_font_shifter_if #(
  parameter int PIX_W = chroni_font_shifter_pkg::PIX_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_font_byte;
  logic [PIX_W-1:0] in_fg;
  logic [PIX_W-1:0] in_bg;
  logic             in_last;

  // Decoder side: offers entries, sees back-pressure.
  modport master (
    output in_valid, in_font_byte, in_fg, in_bg, in_last,
    input  in_ready
  );

  // Shifter side: consumes entries, drives back-pressure.
  modport slave (
    input  in_valid, in_font_byte, in_fg, in_bg, in_last,
    output in_ready
  );

endinterface

// File: rtl/chroni_font_shifter_sync_fifo.sv
// Small synchronous FIFO with one-bit-extended pointers; full/empty come from
// comparing pointer MSBs, so every slot is usable and wrap is natural.
module chroni_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is refused even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer next-state: clear wins over traffic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/full come from the pointers alone.
    if (do_push && !clear && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/chroni_font_shifter.sv
// Chroni font shifter: buffers glyph-row entries and serialises each byte
// MSB-first into colour-index pixels, one per pixel strobe, showing the border
// colour outside the display window or when starved.
module chroni_font_shifter
  import chroni_font_shifter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  chroni_font_shifter_if.slave  in_if,
  input  logic                  pix_en,
  input  logic                  active,
  input  logic [PIX_W-1:0]      border_color,
  output logic [PIX_W-1:0]      pix_out,
  output logic                  line_done,
  output logic                  underrun,
  output logic [7:0]            underrun_count
);

  localparam int ENTRY_W  = entry_width(PIX_W);
  localparam int BG_LSB   = bg_lsb(PIX_W);
  localparam int LAST_BIT = last_bit(PIX_W);

  logic [ENTRY_W-1:0] push_data, head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  shift_state_e     state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [PIX_W-1:0] fg_q, fg_d;
  logic [PIX_W-1:0] bg_q, bg_d;
  logic             last_q, last_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             line_done_q, line_done_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       ucnt_q, ucnt_d;
  logic             strobe;
  logic             load;

  assign in_if.in_ready = !fifo_full && !flush && !reset;
  assign push           = in_if.in_valid && in_if.in_ready;
  assign push_data      = {in_if.in_last, in_if.in_bg, in_if.in_fg, in_if.in_font_byte};
  assign strobe         = pix_en && active;

  chroni_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Shifter next-state, pixel selection, pulses and FIFO pop request.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    line_done_d = 1'b0;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;
    load        = 1'b0;
    pop         = 1'b0;

    if (flush) begin
      state_d = SHIFT_EMPTY;
      cnt_d   = '0;
      pix_d   = border_color;
    end else begin
      case (state_q)
        SHIFT_EMPTY: begin
          if (pix_en) pix_d = border_color;
          if (strobe) begin
            underrun_d = 1'b1;
            if (ucnt_q != UNDERRUN_MAX) ucnt_d = ucnt_q + 8'd1;
          end
          // Loading from the FIFO does not wait for a pixel strobe.
          if (!fifo_empty) load = 1'b1;
        end
        SHIFT_LOADED: begin
          if (strobe) begin
            pix_d = sr_q[7] ? fg_q : bg_q;
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              line_done_d = last_q;
              // Reload on the same edge as the 8th pixel so glyphs abut seamlessly.
              if (!fifo_empty) load = 1'b1;
              else             state_d = SHIFT_EMPTY;
            end
          end else if (pix_en) begin
            pix_d = border_color;
          end
        end
        default: state_d = SHIFT_EMPTY;
      endcase

      if (load) begin
        pop     = 1'b1;
        state_d = SHIFT_LOADED;
        sr_d    = head[BYTE_LSB +: BYTE_W];
        fg_d    = head[FG_LSB +: PIX_W];
        bg_d    = head[BG_LSB +: PIX_W];
        last_d  = head[LAST_BIT];
        cnt_d   = '0;
      end
    end
  end

  // Shifter state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SHIFT_EMPTY;
      sr_q        <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      pix_q       <= '0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign pix_out        = pix_q;
  assign line_done      = line_done_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule
